// File: rtl/gnr_node_lut.sv
// Boolean-network node: slow (s0) and fast (s1) state copies share one truth-table update; s1 activity is counted.
// Optional run-time table writes when GNR_NODE_LUT_WR_EN is defined; otherwise the table is the constant LUT_INIT.
module gnr_node_lut #(
    parameter int                      FANIN    = 4,
    parameter logic [(1<<FANIN)-1:0]   LUT_INIT = '0,
    parameter int                      SLOW_DIV = 2,
    parameter int                      CNT_W    = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_reset_nos,
    input  logic                    i_init_state,
    input  logic                    i_start_s0,
    input  logic                    i_start_s1,
    input  logic [FANIN-1:0]        i_in_s0,
    input  logic [FANIN-1:0]        i_in_s1,
`ifdef GNR_NODE_LUT_WR_EN
    input  logic                    i_lut_wr,
    input  logic [(1<<FANIN)-1:0]   i_lut_wdata,
`endif
    output logic                    o_s0,
    output logic                    o_s1,
    output logic                    o_s1_chg,
    output logic [CNT_W-1:0]        o_act_cnt
);

    localparam int LUT_N = 1 << FANIN;
    localparam int PH_W  = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(SLOW_DIV - 1);

    logic [LUT_N-1:0] w_lut;
    logic             w_nxt0;
    logic             w_nxt1;

    logic             r_s0;
    logic             r_s1;
    logic             r_s1_chg;
    logic [CNT_W-1:0] r_act_cnt;
    logic [PH_W-1:0]  r_phase;

`ifdef GNR_NODE_LUT_WR_EN
    logic [LUT_N-1:0] r_lut;

    // A write in the same cycle as a start still lets that start see the old table.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lut <= LUT_INIT;
        end else if (!i_reset_nos && i_lut_wr) begin
            r_lut <= i_lut_wdata;
        end
    end

    assign w_lut = r_lut;
`else
    assign w_lut = LUT_INIT;
`endif

    assign w_nxt0 = w_lut[i_in_s0];
    assign w_nxt1 = w_lut[i_in_s1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s0      <= 1'b0;
            r_s1      <= 1'b0;
            r_s1_chg  <= 1'b0;
            r_act_cnt <= '0;
            r_phase   <= '0;
        end else if (i_reset_nos) begin
            r_s0      <= i_init_state;
            r_s1      <= i_init_state;
            r_s1_chg  <= 1'b0;
            r_act_cnt <= '0;
            r_phase   <= '0;
        end else begin
            if (i_start_s0) begin
                if (r_phase == '0) begin
                    r_s0 <= w_nxt0;
                end
                r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
            end
            r_s1_chg <= 1'b0;
            if (i_start_s1) begin
                r_s1     <= w_nxt1;
                r_s1_chg <= (w_nxt1 != r_s1);
                if ((w_nxt1 != r_s1) && (r_act_cnt != '1)) begin
                    r_act_cnt <= r_act_cnt + 1'b1;
                end
            end
        end
    end

    assign o_s0      = r_s0;
    assign o_s1      = r_s1;
    assign o_s1_chg  = r_s1_chg;
    assign o_act_cnt = r_act_cnt;

endmodule

// File: doc/gnr_node_lut.md
# gnr_node_lut

Parametrised Boolean-network node for the gene-regulatory-network accelerator. It holds two state copies: s0, a slow copy that advances once every SLOW_DIV start_s0 pulses, and s1, a fast copy that advances on every start_s1 pulse. Both copies use one truth-table (LUT) update function over FANIN neighbour bits, so the network-level comparator can detect attractors with a tortoise/hare scheme. Per-node activity statistics are also kept for the host, which replaces the fixed-function, fixed-rate hand-written nodes.

## Interface
Parameters:
- FANIN, 4, number of regulator inputs (1..6)
- LUT_INIT, {2**FANIN{1'b0}}, truth table loaded at rst; bit i is the next state for input vector i
- SLOW_DIV, 2, s0 advances on every SLOW_DIV-th start_s0 pulse (1..16)
- CNT_W, 16, activity counter width

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-high
- reset_nos  in  1  reload both states from init_state and restart the s0 divider
- init_state  in  1  initial state value
- start_s0  in  1  one-cycle step request for the slow copy
- start_s1  in  1  one-cycle step request for the fast copy
- in_s0  in  FANIN  regulator s0 values; bit j is regulator j
- in_s1  in  FANIN  regulator s1 values
- lut_wr  in  1  truth-table write strobe (only with GNR_NODE_LUT_WR_EN)
- lut_wdata  in  2**FANIN  new truth table
- s0  out  1  slow state
- s1  out  1  fast state
- s1_chg  out  1  pulses for one cycle when an s1 update changed its value
- act_cnt  out  CNT_W  saturating count of s1 value changes since reset_nos

## Operation
- Priority per cycle: rst > reset_nos > {lut_wr, start_s0, start_s1}. The last three are independent of each other.
- rst: s0=0, s1=0, s1_chg=0, act_cnt=0, phase=0, lut=LUT_INIT.
- reset_nos: s0=s1=init_state, phase=0, act_cnt=0, s1_chg=0. Any start pulses in the same cycle are ignored.
- start_s0:
  - If phase==0: s0 <= lut[in_s0].
  - In all cases: phase <= (phase==SLOW_DIV-1) ? 0 : phase+1.
  - SLOW_DIV=1: s0 updates on every pulse, and phase stays 0.
- start_s1: s1 <= lut[in_s1]; s1_chg <= (lut[in_s1] != s1).
  - If the value changed and act_cnt != all-ones, act_cnt increments.
  - act_cnt saturates at 2**CNT_W-1 and never wraps.
- s1_chg is 0 in every cycle without a start_s1.
- lut_wr together with start_s0 or start_s1 in the same cycle: the evaluation uses the old table; the new table applies from the next cycle.
- in_s0 and in_s1 are sampled only in cycles where the corresponding start is high.

## Timing
- All outputs are registered. s0, s1, s1_chg and act_cnt reflect a start pulse one cycle after it.
- There is no combinational path from any input to any output.
- Back-to-back start pulses are legal on every cycle. No handshake and no stall.
- rst or reset_nos asserted mid-sequence takes effect on the next edge regardless of the divider phase.

## Configuration
- GNR_NODE_LUT_WR_EN defined:
  - lut_wr and lut_wdata are present.
  - The truth table is a run-time register, written on lut_wr unless rst or reset_nos is also high in that cycle.
- GNR_NODE_LUT_WR_EN undefined:
  - lut_wr and lut_wdata are removed from the port list.
  - The table is the constant LUT_INIT, so synthesis folds it to logic.
  - All other behaviour is identical.

## Test plan
- FANIN=2, LUT_INIT=4'b1000 (AND), SLOW_DIV=2; rst, then reset_nos with init_state=1; s0=s1=1.
  - in_s0=2'b01 with 4 start_s0 pulses -> s0 goes 0 after pulse 1 and holds after pulses 2-4, because only pulses 1 and 3 evaluate.
  - in_s0=2'b11 from pulse 3 -> s0=1 after pulse 3.
- Same configuration: start_s1 on every cycle with in_s1 toggling 11,00,11,00 from s1=1.
  - s1 sequence 1,0,1,0.
  - s1_chg pattern 0,1,1,1; act_cnt=3.
- CNT_W=2: 5 toggling start_s1 updates -> act_cnt reaches 3 and stays 3. reset_nos -> act_cnt=0.
- Simultaneous reset_nos and start_s0/start_s1 with init_state=0 -> s0=s1=0, phase=0, act_cnt=0, s1_chg=0. The next start_s0 evaluates.
- Build with GNR_NODE_LUT_WR_EN defined: lut_wr=1, lut_wdata=4'b0110 (XOR) in the same cycle as start_s1 with in_s1=2'b01.
  - That update uses AND, giving s1=0.
  - The next start_s1 with in_s1=2'b01 gives s1=1.
- Build without GNR_NODE_LUT_WR_EN, SLOW_DIV=1: every start_s0 updates s0 from LUT_INIT. rst mid-sequence -> s0=0, s1=0 on the next edge.
